// File: rtl/image_window_pkg.sv
// Shared definitions for the image window controller: host command codes and FSM states.
package image_window_pkg;

  localparam logic [3:0] CMD_WRITE    = 4'd0;
  localparam logic [3:0] CMD_UP       = 4'd1;
  localparam logic [3:0] CMD_DOWN     = 4'd2;
  localparam logic [3:0] CMD_LEFT     = 4'd3;
  localparam logic [3:0] CMD_RIGHT    = 4'd4;
  localparam logic [3:0] CMD_AVG      = 4'd5;
  localparam logic [3:0] CMD_MIRROR_X = 4'd6;
  localparam logic [3:0] CMD_MIRROR_Y = 4'd7;
  localparam logic [3:0] CMD_MAX      = 4'd8;
  localparam logic [3:0] CMD_MIN      = 4'd9;
  localparam logic [3:0] CMD_ROT_CW   = 4'd10;
  localparam logic [3:0] CMD_ROT_CCW  = 4'd11;
  localparam logic [3:0] CMD_ORIGIN   = 4'd12;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/image_window_if.sv
// Host command, ROM read and RAM write signals of the image window controller.
// The slave modport is the controller's view; master is the surrounding system.
interface image_window_if #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
);
  localparam int AW = $clog2(IMG_W * IMG_H);

  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          busy;
  logic          done;

  modport master (
    output cmd, cmd_valid, rom_data,
    input  rom_rd, rom_addr, ram_we, ram_addr, ram_wdata, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, rom_data,
    output rom_rd, rom_addr, ram_we, ram_addr, ram_wdata, busy, done
  );

endinterface

// File: rtl/image_window_alu.sv
// Combinational pixel operator for the 2x2 window; cursor and unknown ops pass pixels through.
module image_window_alu
  import image_window_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  output logic [DW-1:0] n_tl,
  output logic [DW-1:0] n_tr,
  output logic [DW-1:0] n_bl,
  output logic [DW-1:0] n_br
);

  logic [DW+1:0] sum_s;
  logic [DW-1:0] avg_s;
  logic [DW-1:0] max_top_s, max_bot_s, max_s;
  logic [DW-1:0] min_top_s, min_bot_s, min_s;

  // Reductions over the four window pixels
  always_comb begin
    sum_s     = (DW+2)'(tl) + (DW+2)'(tr) + (DW+2)'(bl) + (DW+2)'(br);
    avg_s     = DW'(sum_s >> 2);
    max_top_s = (tl > tr) ? tl : tr;
    max_bot_s = (bl > br) ? bl : br;
    max_s     = (max_top_s > max_bot_s) ? max_top_s : max_bot_s;
    min_top_s = (tl < tr) ? tl : tr;
    min_bot_s = (bl < br) ? bl : br;
    min_s     = (min_top_s < min_bot_s) ? min_top_s : min_bot_s;
  end

  // Per-op pixel mapping
  always_comb begin
    n_tl = tl;
    n_tr = tr;
    n_bl = bl;
    n_br = br;
    case (op)
      CMD_AVG:      begin n_tl = avg_s; n_tr = avg_s; n_bl = avg_s; n_br = avg_s; end
      CMD_MAX:      begin n_tl = max_s; n_tr = max_s; n_bl = max_s; n_br = max_s; end
      CMD_MIN:      begin n_tl = min_s; n_tr = min_s; n_bl = min_s; n_br = min_s; end
      CMD_MIRROR_X: begin n_tl = bl;    n_tr = br;    n_bl = tl;    n_br = tr;    end
      CMD_MIRROR_Y: begin n_tl = tr;    n_tr = tl;    n_bl = br;    n_br = bl;    end
      CMD_ROT_CW:   begin n_tl = bl;    n_tr = tl;    n_br = tr;    n_bl = br;    end
      CMD_ROT_CCW:  begin n_tl = tr;    n_tr = br;    n_br = bl;    n_bl = tl;    end
      default:      begin n_tl = tl;    n_tr = tr;    n_bl = bl;    n_br = br;    end
    endcase
  end

endmodule

// File: rtl/image_window_ctrl.sv
// Image window controller: loads the image from ROM, applies host ops to a 2x2 window
// at a movable cursor, and streams the whole buffer to RAM on WRITE.
module image_window_ctrl
  import image_window_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  image_window_if.slave bus
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = AW + 1;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam logic [XW-1:0] X_HOME = XW'(IMG_W / 2 - 1);
  localparam logic [YW-1:0] Y_HOME = YW'(IMG_H / 2 - 1);
  localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 2);

  state_e        state_r, state_nxt_s;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [3:0]    op_r;
  logic [CW-1:0] ld_cnt_r, wr_cnt_r;
  logic          cap_v_r;
  logic [AW-1:0] cap_addr_r;
  logic [DW-1:0] buf_r [NPIX];

  logic          rom_rd_r, ram_we_r, busy_r, done_r;
  logic [AW-1:0] rom_addr_r, ram_addr_r;
  logic [DW-1:0] ram_wdata_r;

  logic [AW-1:0] tl_s, tr_s, bl_s, br_s;
  logic [DW-1:0] new_tl_s, new_tr_s, new_bl_s, new_br_s;
  logic          load_last_s, write_last_s;

  assign tl_s = AW'(int'(y_r) * IMG_W + int'(x_r));
  assign tr_s = tl_s + AW'(1);
  assign bl_s = tl_s + AW'(IMG_W);
  assign br_s = bl_s + AW'(1);

  // ROM data lags the address by one cycle, so the last capture is the pipelined address NPIX-1
  assign load_last_s  = cap_v_r && (cap_addr_r == AW'(NPIX - 1));
  assign write_last_s = (wr_cnt_r == CW'(NPIX));

  image_window_alu #(.DW(DW)) u_alu (
    .op   (op_r),
    .tl   (buf_r[tl_s]),
    .tr   (buf_r[tr_s]),
    .bl   (buf_r[bl_s]),
    .br   (buf_r[br_s]),
    .n_tl (new_tl_s),
    .n_tr (new_tr_s),
    .n_bl (new_bl_s),
    .n_br (new_br_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_LOAD;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (load_last_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_LOAD;
      end
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd == CMD_WRITE) state_nxt_s = ST_WRITE;
          else                      state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_IDLE;
      ST_WRITE: begin
        if (write_last_s) state_nxt_s = ST_IDLE;
        else              state_nxt_s = ST_WRITE;
      end
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // Sequencing of ROM/RAM ports, handshake flags and cursor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_rd_r    <= 1'b0;
      rom_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      busy_r      <= 1'b1;
      done_r      <= 1'b0;
      x_r         <= X_HOME;
      y_r         <= Y_HOME;
      op_r        <= 4'd0;
      ld_cnt_r    <= '0;
      wr_cnt_r    <= '0;
      cap_v_r     <= 1'b0;
      cap_addr_r  <= '0;
    end else begin
      cap_v_r    <= rom_rd_r;
      cap_addr_r <= rom_addr_r;
      case (state_r)
        ST_LOAD: begin
          if (ld_cnt_r < CW'(NPIX)) begin
            rom_rd_r   <= 1'b1;
            rom_addr_r <= ld_cnt_r[AW-1:0];
            ld_cnt_r   <= ld_cnt_r + CW'(1);
          end else begin
            rom_rd_r <= 1'b0;
          end
          if (load_last_s) busy_r <= 1'b0;
        end
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            op_r     <= bus.cmd;
            wr_cnt_r <= '0;
          end
        end
        ST_EXEC: begin
          busy_r <= 1'b0;
          case (op_r)
            CMD_UP:     if (y_r != YW'(0)) y_r <= y_r - YW'(1);
            CMD_DOWN:   if (y_r < Y_MAX)   y_r <= y_r + YW'(1);
            CMD_LEFT:   if (x_r != XW'(0)) x_r <= x_r - XW'(1);
            CMD_RIGHT:  if (x_r < X_MAX)   x_r <= x_r + XW'(1);
            CMD_ORIGIN: begin x_r <= X_HOME; y_r <= Y_HOME; end
            default:    ;
          endcase
        end
        ST_WRITE: begin
          if (!write_last_s) begin
            ram_we_r    <= 1'b1;
            ram_addr_r  <= wr_cnt_r[AW-1:0];
            ram_wdata_r <= buf_r[wr_cnt_r[AW-1:0]];
            wr_cnt_r    <= wr_cnt_r + CW'(1);
          end else begin
            ram_we_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel buffer: ROM capture during load, window commit on exec; contents survive reset
  always_ff @(posedge clk) begin
    if (cap_v_r) begin
      buf_r[cap_addr_r] <= bus.rom_data;
    end else if (state_r == ST_EXEC) begin
      buf_r[tl_s] <= new_tl_s;
      buf_r[tr_s] <= new_tr_s;
      buf_r[bl_s] <= new_bl_s;
      buf_r[br_s] <= new_br_s;
    end
  end

  assign bus.rom_rd    = rom_rd_r;
  assign bus.rom_addr  = rom_addr_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_image_window_ctrl.sv
// Self-checking bench for image_window_ctrl (8x8, 8-bit) against an array-based image model.
module tb_image_window_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int DW    = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] rom_mem [NPIX];
  int model_img [NPIX];
  int cx;
  int cy;

  image_window_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) bus ();

  image_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for the address seen at an edge appears after that edge
  always_ff @(posedge clk) begin
    if (bus.rom_rd === 1'b1) bus.rom_data <= rom_mem[bus.rom_addr];
  end

  function automatic void model_exec(input int c);
    int idx[4];
    int v[4];
    int n[4];
    int s;
    int mx;
    int mn;
    idx[0] = cy * IMG_W + cx;
    idx[1] = idx[0] + 1;
    idx[2] = idx[0] + IMG_W;
    idx[3] = idx[2] + 1;
    s = 0; mx = 0; mn = 1 << DW;
    for (int i = 0; i < 4; i++) begin
      v[i] = model_img[idx[i]];
      n[i] = v[i];
      s += v[i];
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
    case (c)
      1:  if (cy > 0) cy--;
      2:  if (cy < IMG_H - 2) cy++;
      3:  if (cx > 0) cx--;
      4:  if (cx < IMG_W - 2) cx++;
      5:  for (int i = 0; i < 4; i++) n[i] = s / 4;
      6:  n = '{v[2], v[3], v[0], v[1]};
      7:  n = '{v[1], v[0], v[3], v[2]};
      8:  for (int i = 0; i < 4; i++) n[i] = mx;
      9:  for (int i = 0; i < 4; i++) n[i] = mn;
      10: n = '{v[2], v[0], v[3], v[1]};
      11: n = '{v[1], v[3], v[0], v[2]};
      12: begin cx = IMG_W / 2 - 1; cy = IMG_H / 2 - 1; end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) model_img[idx[i]] = n[i];
  endfunction

  task automatic test_reset();
    int k;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rom_rd, bus.ram_we} !== 4'b1000)
      $display("FAIL reset_flags got busy/done/rom_rd/ram_we=%b expected 1000",
               {bus.busy, bus.done, bus.rom_rd, bus.ram_we});
    if ({bus.busy, bus.done, bus.rom_rd, bus.ram_we} !== 4'b1000) errors++;
    checks++;
    if (bus.rom_addr !== 6'd0 || bus.ram_addr !== 6'd0 || bus.ram_wdata !== 8'd0) begin
      errors++;
      $display("FAIL reset_bus got rom_addr=%0d ram_addr=%0d ram_wdata=%0d expected 0 0 0",
               bus.rom_addr, bus.ram_addr, bus.ram_wdata);
    end
    reset = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        checks++;
        if (bus.rom_rd !== 1'b1 || bus.rom_addr !== 6'd0) begin
          errors++;
          $display("FAIL load_start got rom_rd=%b rom_addr=%0d expected 1 0", bus.rom_rd, bus.rom_addr);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.rom_addr !== 6'd1) begin
          errors++;
          $display("FAIL load_addr1 got %0d expected 1", bus.rom_addr);
        end
      end
      if (bus.busy === 1'b0) break;
    end
    checks++;
    if (k != NPIX + 2 || bus.rom_rd !== 1'b0) begin
      errors++;
      $display("FAIL load_latency got cycle=%0d rom_rd=%b expected cycle=%0d rom_rd=0", k, bus.rom_rd, NPIX + 2);
    end
    for (int i = 0; i < NPIX; i++) model_img[i] = int'(rom_mem[i]);
    cx = IMG_W / 2 - 1;
    cy = IMG_H / 2 - 1;
  endtask

  // Issue one command; WRITE streams are checked pixel by pixel. poke>=0 injects RIGHT mid-write.
  task automatic issue(input int c, input int poke);
    int n;
    int w;
    w = 0;
    while (bus.busy !== 1'b0 && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got busy=%b expected 0", bus.busy);
      return;
    end
    bus.cmd = 4'(c);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL accept cmd=%0d got busy=%b done=%b expected 1 0", c, bus.busy, bus.done);
    end
    if (c != 0) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL exec_busy cmd=%0d got busy=%b expected 0", c, bus.busy);
      end
      model_exec(c);
    end else begin
      n = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        if (cyc == poke) begin
          bus.cmd = 4'd4;
          bus.cmd_valid = 1'b1;
        end else begin
          bus.cmd_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (bus.ram_we === 1'b1) begin
          checks++;
          if (bus.ram_addr !== AW'(n) || bus.ram_wdata !== DW'(model_img[n % NPIX])) begin
            errors++;
            $display("FAIL wr_pixel got addr=%0d data=%0d expected addr=%0d data=%0d",
                     bus.ram_addr, bus.ram_wdata, n, model_img[n % NPIX]);
          end
          n++;
        end
        if (bus.busy === 1'b0) break;
      end
      bus.cmd_valid = 1'b0;
      checks++;
      if (n != NPIX || bus.done !== 1'b1 || bus.ram_we !== 1'b0) begin
        errors++;
        $display("FAIL write_end got count=%0d done=%b ram_we=%b expected %0d 1 0", n, bus.done, bus.ram_we, NPIX);
      end
    end
  endtask

  task automatic rom_identity();
    for (int i = 0; i < NPIX; i++) rom_mem[i] = DW'(i);
  endtask

  task automatic test_load_write();
    rom_identity();
    test_reset();
    issue(0, -1);
  endtask

  task automatic test_avg();
    rom_identity();
    test_reset();
    issue(5, -1);
    issue(0, -1);
  endtask

  task automatic test_edge_saturation();
    rom_identity();
    test_reset();
    repeat (5) issue(1, -1);
    issue(6, -1);
    issue(0, -1);
    test_reset();
    repeat (10) issue(4, -1);
    issue(10, -1);
    issue(0, -1);
    repeat (10) issue(2, -1);
    repeat (10) issue(3, -1);
    issue(11, -1);
    issue(7, -1);
    issue(0, -1);
  endtask

  task automatic test_max_min();
    rom_identity();
    rom_mem[28] = 8'd255;
    test_reset();
    issue(8, -1);
    issue(12, -1);
    issue(9, -1);
    issue(0, -1);
  endtask

  task automatic test_busy_protocol();
    rom_identity();
    test_reset();
    issue(0, 10);
    issue(10, -1);
    issue(0, -1);
    issue(13, -1);
    issue(0, -1);
  endtask

  task automatic test_reset_mid_write();
    int k;
    rom_identity();
    test_reset();
    issue(0, -1);
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (bus.ram_we === 1'b1 && bus.ram_addr === 6'd20) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (k == 100) begin
      errors++;
      $display("FAIL mid_write_reach got ram_addr=%0d expected 20", bus.ram_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ram_we !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_write_reset got ram_we=%b busy=%b done=%b expected 0 1 0", bus.ram_we, bus.busy, bus.done);
    end
    test_reset();
    issue(5, -1);
    issue(0, -1);
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < NPIX; i++) rom_mem[i] = DW'($urandom_range(0, 255));
    test_reset();
    for (int i = 0; i < 60; i++) begin
      c = int'($urandom_range(0, 15));
      issue(c, (c == 0) ? int'($urandom_range(2, 40)) : -1);
    end
    issue(0, -1);
  endtask

  initial begin
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    rom_identity();
    test_load_write();
    test_avg();
    test_edge_saturation();
    test_max_min();
    test_busy_protocol();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
